// File: rtl/demux_router_pkg.sv
// Shared defaults and helpers for the registered 1:N demultiplexer.
package demux_router_pkg;

    localparam int DEF_DW    = 8;
    localparam int DEF_N_OUT = 4;
    localparam int DEF_CW    = 8;

    // True when a select value addresses an existing output channel.
    function automatic logic sel_in_range(input int sel, input int n);
        return sel < n;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry holding register for a single output channel.
// Accepts a push whenever it is empty or being drained in the same cycle.
module demux_out_slot #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic          valid,
    output logic [DW-1:0] dout,
    output logic          free
);

    // The slot can take a new beat when it is empty or its beat leaves now.
    assign free = !valid || pop;

    // Hold register: a push overrides a pop, otherwise a pop empties the slot.
    always_ff @(posedge clk) begin
        // NOTE: the data register is reset as well, so a beat discarded by
        // reset never reappears on dout and the reset value is defined.
        if (!rst_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (push) begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, independent of statement order.
            valid <= 1'b1;
            dout  <= din;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_reg_router.sv
// Registered 1:N demultiplexer with valid/ready handshake.
// Decodes s_sel, steers accepted beats into per-channel holding slots,
// and sinks out-of-range beats with an error pulse and a saturating count.
module demux_reg_router
    import demux_router_pkg::*;
#(
    parameter  int DW    = DEF_DW,
    parameter  int N_OUT = DEF_N_OUT,
    parameter  int CW    = DEF_CW,
    localparam int SW    = (N_OUT > 2) ? $clog2(N_OUT) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SW-1:0]       s_sel,
    input  logic [DW-1:0]       s_data,
    output logic [N_OUT-1:0]    m_valid,
    input  logic [N_OUT-1:0]    m_ready,
    output logic [N_OUT*DW-1:0] m_data,
    output logic                sel_err,
    output logic [CW-1:0]       drop_cnt
);

    logic             sel_ok;
    logic             drop;
    logic [N_OUT-1:0] slot_free;
    logic [N_OUT-1:0] push;

    assign sel_ok = sel_in_range(int'(s_sel), N_OUT);

    // An out-of-range beat is always sunk, so s_ready is 1 and it drops on s_valid.
    assign drop = s_valid && !sel_ok;

    // Select decode: s_ready follows only the addressed slot; push only that slot.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        s_ready = !sel_ok;
        push    = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (sel_ok && (s_sel == SW'(k))) begin
                s_ready = slot_free[k];
                push[k] = s_valid && slot_free[k];
            end
        end
    end

    // One holding slot per output channel; each drains independently.
    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        demux_out_slot #(
            .DW (DW)
        ) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[k]),
            .pop   (m_valid[k] && m_ready[k]),
            .din   (s_data),
            .valid (m_valid[k]),
            .dout  (m_data[k*DW +: DW]),
            .free  (slot_free[k])
        );
    end

    // Error pulse for the cycle after a drop, and a counter that sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_err  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            sel_err <= drop;
            if (drop && (drop_cnt != {CW{1'b1}})) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux_reg_router.sv
// Self-checking bench for demux_reg_router: a 4-channel instance (CW=8)
// and a 3-channel instance (CW=2) checked against an occupancy model every
// cycle, plus hand-computed directed expectations.
module tb_demux_reg_router;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: N_OUT=4, CW=8
    logic        a_valid, a_ready_s;
    logic [1:0]  a_sel;
    logic [7:0]  a_data;
    logic [3:0]  a_mvalid, a_mready;
    logic [31:0] a_mdata;
    logic        a_err;
    logic [7:0]  a_cnt;

    // Instance B: N_OUT=3, CW=2
    logic        b_valid, b_ready_s;
    logic [1:0]  b_sel;
    logic [7:0]  b_data;
    logic [2:0]  b_mvalid, b_mready;
    logic [23:0] b_mdata;
    logic        b_err;
    logic [1:0]  b_cnt;

    demux_reg_router #(.DW(8), .N_OUT(4), .CW(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_valid(a_valid), .s_ready(a_ready_s),
        .s_sel(a_sel), .s_data(a_data), .m_valid(a_mvalid), .m_ready(a_mready),
        .m_data(a_mdata), .sel_err(a_err), .drop_cnt(a_cnt)
    );

    demux_reg_router #(.DW(8), .N_OUT(3), .CW(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_valid(b_valid), .s_ready(b_ready_s),
        .s_sel(b_sel), .s_data(b_data), .m_valid(b_mvalid), .m_ready(b_mready),
        .m_data(b_mdata), .sel_err(b_err), .drop_cnt(b_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: each channel is a one-deep queue (occupancy count)
    // plus the last data value ever written to it.
    int         occ   [2][4];
    logic [7:0] last  [2][4];
    int         drops [2];
    bit         err_e [2];
    bit         model_on = 1'b0;

    function automatic bit exp_ready(input int i, input int n, input logic [1:0] sel,
                                     input logic [3:0] rdy);
        if (int'(sel) >= n) return 1'b1;
        return (occ[i][sel] == 0) || rdy[sel];
    endfunction

    task automatic model_edge(input int i, input int n, input logic v, input logic [1:0] sel,
                              input logic [7:0] d, input logic [3:0] rdy, input logic rst);
        bit acc;
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                occ[i][k]  = 0;
                last[i][k] = 8'h00;
            end
            drops[i] = 0;
            err_e[i] = 1'b0;
            return;
        end
        acc      = v && exp_ready(i, n, sel, rdy);
        err_e[i] = 1'b0;
        for (int k = 0; k < n; k++)
            if (occ[i][k] != 0 && rdy[k]) occ[i][k] = 0;
        if (acc) begin
            if (int'(sel) < n) begin
                occ[i][sel]  = 1;
                last[i][sel] = d;
            end else begin
                drops[i]++;
                err_e[i] = 1'b1;
            end
        end
    endtask

    // Advance the model on every active edge from the pre-edge inputs.
    always @(posedge clk) begin
        model_edge(0, 4, a_valid, a_sel, a_data, a_mready, rst_n);
        model_edge(1, 3, b_valid, b_sel, b_data, {1'b0, b_mready}, rst_n);
        if (!rst_n) model_on = 1'b1;
    end

    // Compare every DUT output against the model on the falling edge.
    always @(negedge clk) begin
        logic [3:0]  ev;
        logic [31:0] ed;
        if (model_on) begin
            ev = '0; ed = '0;
            for (int k = 0; k < 4; k++) begin
                ev[k]        = occ[0][k] != 0;
                ed[k*8 +: 8] = last[0][k];
            end
            check("a_m_valid",  {28'b0, a_mvalid}, {28'b0, ev});
            check("a_m_data",   a_mdata, ed);
            check("a_s_ready",  {31'b0, a_ready_s}, {31'b0, exp_ready(0, 4, a_sel, a_mready)});
            check("a_sel_err",  {31'b0, a_err}, {31'b0, err_e[0]});
            check("a_drop_cnt", {24'b0, a_cnt}, (drops[0] > 255) ? 32'd255 : 32'(drops[0]));
            ev = '0; ed = '0;
            for (int k = 0; k < 3; k++) begin
                ev[k]        = occ[1][k] != 0;
                ed[k*8 +: 8] = last[1][k];
            end
            check("b_m_valid",  {29'b0, b_mvalid}, {28'b0, ev});
            check("b_m_data",   {8'b0, b_mdata}, ed);
            check("b_s_ready",  {31'b0, b_ready_s}, {31'b0, exp_ready(1, 3, b_sel, {1'b0, b_mready})});
            check("b_sel_err",  {31'b0, b_err}, {31'b0, err_e[1]});
            check("b_drop_cnt", {30'b0, b_cnt}, (drops[1] > 3) ? 32'd3 : 32'(drops[1]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_valid = 1'b1; a_sel = 2'd0; a_data = 8'h77; a_mready = 4'hF;
        b_valid = 1'b1; b_sel = 2'd3; b_data = 8'h66; b_mready = 3'h7;

        // Reset with s_valid held high for 3 cycles
        repeat (3) step();
        check("rst_a_m_valid",  {28'b0, a_mvalid}, 32'h0);
        check("rst_a_m_data",   a_mdata, 32'h0);
        check("rst_a_drop_cnt", {24'b0, a_cnt}, 32'h0);
        check("rst_a_sel_err",  {31'b0, a_err}, 32'h0);
        check("rst_b_drop_cnt", {30'b0, b_cnt}, 32'h0);
        rst_n = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        step();

        // Routing: back-to-back beats to channels 0..3, all consumers ready
        for (int k = 0; k < 4; k++) begin
            a_valid = 1'b1; a_sel = 2'(k); a_data = 8'hA0 + 8'(k);
            #1 check("route_s_ready", {31'b0, a_ready_s}, 32'h1);
            step();
            check("route_m_valid", {28'b0, a_mvalid}, 32'h1 << k);
            check("route_m_data",  {24'b0, a_mdata[k*8 +: 8]}, 32'hA0 + k);
        end
        a_valid = 1'b0;
        step();
        check("route_drain", {28'b0, a_mvalid}, 32'h0);

        // Backpressure on channel 2
        a_mready = 4'b1011;
        a_valid = 1'b1; a_sel = 2'd2; a_data = 8'h11;
        step();
        a_data = 8'h22;
        #1 check("bp_s_ready_low", {31'b0, a_ready_s}, 32'h0);
        step();
        check("bp_hold_data",  {24'b0, a_mdata[23:16]}, 32'h11);
        check("bp_hold_valid", {28'b0, a_mvalid}, 32'h4);
        a_mready = 4'hF;
        #1 check("bp_s_ready_high", {31'b0, a_ready_s}, 32'h1);
        step();
        check("bp_replace_valid", {28'b0, a_mvalid}, 32'h4);
        check("bp_replace_data",  {24'b0, a_mdata[23:16]}, 32'h22);
        check("bp_other_chans",   {a_mdata[31:24], a_mdata[15:0]}, 32'h00A3A1A0);
        a_valid = 1'b0;
        step();
        check("bp_drain", {28'b0, a_mvalid}, 32'h0);

        // Out of range on the 3-channel instance
        b_valid = 1'b1; b_sel = 2'b11; b_data = 8'hFF;
        #1 check("oor_s_ready", {31'b0, b_ready_s}, 32'h1);
        step();
        check("oor_sel_err",  {31'b0, b_err}, 32'h1);
        check("oor_drop_cnt", {30'b0, b_cnt}, 32'h1);
        check("oor_m_valid",  {29'b0, b_mvalid}, 32'h0);
        b_valid = 1'b0;
        step();
        check("oor_err_pulse", {31'b0, b_err}, 32'h0);
        b_valid = 1'b1;
        repeat (4) step();
        b_valid = 1'b0;
        step();
        check("oor_saturated", {30'b0, b_cnt}, 32'h3);
        // Highest legal channel still routes
        b_valid = 1'b1; b_sel = 2'd2; b_data = 8'h3C;
        step();
        b_valid = 1'b0;
        check("top_chan_valid", {29'b0, b_mvalid}, 32'h4);
        check("top_chan_data",  {24'b0, b_mdata[23:16]}, 32'h3C);
        check("top_chan_cnt",   {30'b0, b_cnt}, 32'h3);
        step();

        // Reset mid-operation discards a held beat
        a_mready = 4'b1101;
        a_valid = 1'b1; a_sel = 2'd1; a_data = 8'h5A;
        step();
        a_valid = 1'b0;
        check("mid_held", {24'b0, a_mdata[15:8]}, 32'h5A);
        step();
        rst_n = 1'b0;
        step();
        check("mid_rst_valid", {28'b0, a_mvalid}, 32'h0);
        check("mid_rst_data",  a_mdata, 32'h0);
        check("mid_rst_b_cnt", {30'b0, b_cnt}, 32'h0);
        rst_n = 1'b1; a_mready = 4'hF;
        repeat (3) step();
        check("mid_never_delivered", {28'b0, a_mvalid}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
